// File: rtl/regfile_read_port_pair_if.sv
// Decode/execute-facing bus of the 16-entry register file: one write port and
// two registered read ports with valid and one-hot read wordlines.
interface regfile_read_port_pair_if #(
  parameter int WIDTH = 16
);
  logic             WriteReg;
  logic [3:0]       DstReg;
  logic [WIDTH-1:0] DstData;
  logic             ReadEn1;
  logic [3:0]       SrcReg1;
  logic             ReadEn2;
  logic [3:0]       SrcReg2;
  logic [WIDTH-1:0] SrcData1;
  logic [WIDTH-1:0] SrcData2;
  logic             RdValid1;
  logic             RdValid2;
  logic [15:0]      RdSel1;
  logic [15:0]      RdSel2;

  modport master (
    output WriteReg, DstReg, DstData, ReadEn1, SrcReg1, ReadEn2, SrcReg2,
    input  SrcData1, SrcData2, RdValid1, RdValid2, RdSel1, RdSel2
  );

  modport slave (
    input  WriteReg, DstReg, DstData, ReadEn1, SrcReg1, ReadEn2, SrcReg2,
    output SrcData1, SrcData2, RdValid1, RdValid2, RdSel1, RdSel2
  );
endinterface

// File: rtl/regfile_read_port_pair.sv
// 16 x WIDTH register file, R0 hardwired to zero, two registered read ports.
// Optional macro RF_BYPASS_EN: same-cycle write data is forwarded to a read.

module regfile_rd_port #(
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rd_en,
  input  logic [3:0]             rd_addr,
  input  logic [15:0][WIDTH-1:0] regs,
  input  logic                   byp,
  input  logic [WIDTH-1:0]       byp_data,
  output logic [15:0]            rd_sel,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_vld
);
  localparam int STAGES = 1;

  logic [STAGES:0]  vld_pipe;
  logic [WIDTH-1:0] mux;
  logic [WIDTH-1:0] nxt;

  always_comb begin
    rd_sel = '0;
    if (rd_en) rd_sel = 16'h0001 << rd_addr;
  end

  // Plain AND-OR: rd_sel is one-hot so no priority is needed.
  always_comb begin
    mux = '0;
    for (int i = 0; i < 16; i++) mux = mux | (regs[i] & {WIDTH{rd_sel[i]}});
  end

  assign nxt = byp ? byp_data : mux;

  assign vld_pipe[0] = rd_en;
  assign rd_vld      = vld_pipe[STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[STAGES:1] <= '0;
      rd_data            <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      if (rd_en) rd_data <= nxt;
    end
  end
endmodule

module regfile_read_port_pair #(
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  regfile_read_port_pair_if.slave  bus
);
  localparam int NUM_LANES = 2;

  logic [15:0][WIDTH-1:0] regs;
  logic [15:0]            wr_sel;

  logic [NUM_LANES-1:0]             rd_en;
  logic [NUM_LANES-1:0][3:0]        rd_addr;
  logic [NUM_LANES-1:0]             byp;
  logic [NUM_LANES-1:0][15:0]       rd_sel;
  logic [NUM_LANES-1:0][WIDTH-1:0]  rd_data;
  logic [NUM_LANES-1:0]             rd_vld;

  // Write wordline; bit 0 masked so R0 never leaves its reset value.
  always_comb begin
    wr_sel = '0;
    if (bus.WriteReg) wr_sel = 16'h0001 << bus.DstReg;
    wr_sel[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else begin
      for (int i = 1; i < 16; i++)
        if (wr_sel[i]) regs[i] <= bus.DstData;
    end
  end

  assign rd_en   = {bus.ReadEn2, bus.ReadEn1};
  assign rd_addr = {bus.SrcReg2, bus.SrcReg1};

  generate
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
`ifdef RF_BYPASS_EN
      assign byp[l] = bus.WriteReg && (bus.DstReg == rd_addr[l]) && (rd_addr[l] != 4'd0);
`else
      assign byp[l] = 1'b0;
`endif
      regfile_rd_port #(.WIDTH(WIDTH)) u_rd (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_en    (rd_en[l]),
        .rd_addr  (rd_addr[l]),
        .regs     (regs),
        .byp      (byp[l]),
        .byp_data (bus.DstData),
        .rd_sel   (rd_sel[l]),
        .rd_data  (rd_data[l]),
        .rd_vld   (rd_vld[l])
      );
    end
  endgenerate

  assign bus.RdSel1   = rd_sel[0];
  assign bus.RdSel2   = rd_sel[1];
  assign bus.SrcData1 = rd_data[0];
  assign bus.SrcData2 = rd_data[1];
  assign bus.RdValid1 = rd_vld[0];
  assign bus.RdValid2 = rd_vld[1];
endmodule

// File: tb/tb_regfile_read_port_pair.sv
// Random + directed bench for regfile_read_port_pair against an array model.
module tb_regfile_read_port_pair;
  localparam int WIDTH = 16;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_read_port_pair_if #(.WIDTH(WIDTH)) bus ();
  regfile_read_port_pair #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] mdl [16];
  logic [WIDTH-1:0] e_d [2];
  logic             e_v [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.WriteReg = 1'b0; bus.DstReg = 4'd0; bus.DstData = '0;
    bus.ReadEn1 = 1'b0; bus.SrcReg1 = 4'd0;
    bus.ReadEn2 = 1'b0; bus.SrcReg2 = 4'd0;
  endtask

  // Starts and ends on a falling edge; one rising edge in between.
  task automatic step(input logic we, input logic [3:0] dst, input logic [WIDTH-1:0] dat,
                      input logic en1, input logic [3:0] s1,
                      input logic en2, input logic [3:0] s2);
    logic       en [2];
    logic [3:0] s  [2];
    en[0] = en1; en[1] = en2; s[0] = s1; s[1] = s2;
    bus.WriteReg = we; bus.DstReg = dst; bus.DstData = dat;
    bus.ReadEn1 = en1; bus.SrcReg1 = s1; bus.ReadEn2 = en2; bus.SrcReg2 = s2;
    #1;
    chk("rdsel1", 32'(bus.RdSel1), en1 ? (32'd1 << s1) : 32'd0);
    chk("rdsel2", 32'(bus.RdSel2), en2 ? (32'd1 << s2) : 32'd0);
    for (int p = 0; p < 2; p++) begin
      if (en[p]) begin
        if (s[p] == 4'd0)                      e_d[p] = '0;
        else if (BYP && we && dst == s[p])     e_d[p] = dat;
        else                                   e_d[p] = mdl[s[p]];
      end
      e_v[p] = en[p];
    end
    if (we && dst != 4'd0) mdl[dst] = dat;
    @(posedge clk);
    @(negedge clk);
    chk("data1",  32'(bus.SrcData1), 32'(e_d[0]));
    chk("data2",  32'(bus.SrcData2), 32'(e_d[1]));
    chk("valid1", 32'(bus.RdValid1), 32'(e_v[0]));
    chk("valid2", 32'(bus.RdValid2), 32'(e_v[1]));
  endtask

  // Called on a falling edge; reset pulse sits entirely between clock edges.
  task automatic do_reset();
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_data1",  32'(bus.SrcData1), 32'd0);
    chk("rst_data2",  32'(bus.SrcData2), 32'd0);
    chk("rst_valid1", 32'(bus.RdValid1), 32'd0);
    chk("rst_valid2", 32'(bus.RdValid2), 32'd0);
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    for (int p = 0; p < 2; p++) begin e_d[p] = '0; e_v[p] = 1'b0; end
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid1", 32'(bus.RdValid1), 32'd0);
    chk("post_rst_data1",  32'(bus.SrcData1), 32'd0);
  endtask

  initial begin
    idle();
    @(negedge clk);
    do_reset();

    // Reset then read R5
    step(1'b0, 4'd0, '0, 1'b1, 4'd5, 1'b0, 4'd0);
    chk("r5_after_reset", 32'(bus.SrcData1), 32'h0000);
    chk("r5_valid", 32'(bus.RdValid1), 32'd1);

    // Dual-port write/read back
    step(1'b1, 4'd3,  16'hBEEF, 1'b0, 4'd0, 1'b0, 4'd0);
    step(1'b1, 4'd12, 16'h1234, 1'b0, 4'd0, 1'b0, 4'd0);
    bus.ReadEn1 = 1'b1; bus.SrcReg1 = 4'd3; bus.ReadEn2 = 1'b1; bus.SrcReg2 = 4'd12;
    #1;
    chk("sel1_r3",  32'(bus.RdSel1), 32'h0008);
    chk("sel2_r12", 32'(bus.RdSel2), 32'h1000);
    step(1'b0, 4'd0, '0, 1'b1, 4'd3, 1'b1, 4'd12);
    chk("rd_r3",  32'(bus.SrcData1), 32'hBEEF);
    chk("rd_r12", 32'(bus.SrcData2), 32'h1234);

    // R0 protection
    step(1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0, 1'b0, 4'd0);
    step(1'b0, 4'd0, '0, 1'b1, 4'd0, 1'b1, 4'd0);
    chk("r0_p1", 32'(bus.SrcData1), 32'h0000);
    chk("r0_p2", 32'(bus.SrcData2), 32'h0000);
    // R0 write racing an R0 read must not forward either
    step(1'b1, 4'd0, 16'hFFFF, 1'b1, 4'd0, 1'b1, 4'd0);
    chk("r0_race", 32'(bus.SrcData1), 32'h0000);

    // Same-cycle hazard on R7
    step(1'b1, 4'd7, 16'h0001, 1'b0, 4'd0, 1'b0, 4'd0);
    step(1'b1, 4'd7, 16'h00AA, 1'b1, 4'd7, 1'b0, 4'd0);
    chk("hazard", 32'(bus.SrcData1), BYP ? 32'h00AA : 32'h0001);
    step(1'b0, 4'd0, '0, 1'b1, 4'd7, 1'b0, 4'd0);
    chk("hazard_reread", 32'(bus.SrcData1), 32'h00AA);

    // Hold while idle and R3 is overwritten
    step(1'b0, 4'd0, '0, 1'b1, 4'd3, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'd3, 16'h5555, 1'b0, 4'd3, 1'b0, 4'd0);
      chk("hold_data",  32'(bus.SrcData1), 32'hBEEF);
      chk("hold_valid", 32'(bus.RdValid1), 32'd0);
      chk("hold_sel",   32'(bus.RdSel1),   32'd0);
    end

    // Randomized traffic, reads biased toward the register being written
    for (int n = 0; n < 400; n++) begin
      logic       we, en1, en2;
      logic [3:0] dst, s1, s2;
      logic [WIDTH-1:0] dat;
      we  = 1'($urandom_range(0, 1));
      dst = 4'($urandom);
      dat = WIDTH'($urandom);
      en1 = 1'($urandom_range(0, 3) != 0);
      en2 = 1'($urandom_range(0, 3) != 0);
      s1  = ($urandom_range(0, 3) == 0) ? dst : 4'($urandom);
      s2  = ($urandom_range(0, 3) == 0) ? s1  : 4'($urandom);
      step(we, dst, dat, en1, s1, en2, s2);
    end

    // Reset during an in-flight read
    step(1'b1, 4'd9, 16'hCAFE, 1'b0, 4'd0, 1'b0, 4'd0);
    step(1'b0, 4'd0, '0, 1'b1, 4'd9, 1'b1, 4'd9);
    chk("pre_rst_data", 32'(bus.SrcData1), 32'hCAFE);
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b0, 4'd0, '0, 1'b1, 4'(i), 1'b1, 4'(15 - i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
